board_ctl: RTL and testbench

Playfield store on the receiving end of the falling-block position interface. The piece controller hands it a landed cell as (row, column) through a valid/ready handshake. The block writes the cell into a ROWS x COLS occupancy grid, then detects and clears full lines by shifting the rows above them down. It also answers collision queries from the controller and serves a registered cell-read port to the VGA draw path.

---
 rtl/board_pkg.sv | 34 +++
 rtl/board_ctl_if.sv | 23 ++
 rtl/board_score.sv | 30 +++
 rtl/board_ctl.sv | 149 ++++++++++++++
 tb/tb_board_ctl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// Shared constants, FSM encoding and score lookup for the playfield store.
package board_pkg;

  localparam int unsigned ROWS_DEF   = 20;
  localparam int unsigned COLS_DEF   = 10;
  localparam int unsigned RW_DEF     = 5;
  localparam int unsigned CW_DEF     = 4;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned LINE_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    SCAN  = 2'd2,
    SHIFT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SCORE_1 = 16'd1;
  localparam logic [CNT_W-1:0] SCORE_2 = 16'd3;
  localparam logic [CNT_W-1:0] SCORE_3 = 16'd5;
  localparam logic [CNT_W-1:0] SCORE_4 = 16'd8;

  // Points for the number of lines one lock cleared; 4 or more pays the top rate.
  function automatic logic [CNT_W-1:0] line_score(input logic [LINE_CNT_W-1:0] n);
    case (n)
      3'd0:    line_score = '0;
      3'd1:    line_score = SCORE_1;
      3'd2:    line_score = SCORE_2;
      3'd3:    line_score = SCORE_3;
      default: line_score = SCORE_4;
    endcase
  endfunction

endpackage

// File: rtl/board_ctl_if.sv
// Piece-controller side of the playfield: lock handshake and collision query.
interface board_ctl_if #(
  parameter int unsigned RW = board_pkg::RW_DEF,
  parameter int unsigned CW = board_pkg::CW_DEF
);
  logic          lock_valid;
  logic [RW-1:0] lock_row;
  logic [CW-1:0] lock_col;
  logic          lock_ready;
  logic [RW-1:0] q_row;
  logic [CW-1:0] q_col;
  logic          q_occupied;

  modport master (
    output lock_valid, lock_row, lock_col, q_row, q_col,
    input  lock_ready, q_occupied
  );

  modport slave (
    input  lock_valid, lock_row, lock_col, q_row, q_col,
    output lock_ready, q_occupied
  );
endinterface

// File: rtl/board_score.sv
// Per-lock line counter and saturating score accumulator.
module board_score
  import board_pkg::*;
(
  input  logic             pclk,
  input  logic             rst,
  input  logic             line_inc,
  input  logic             lock_done,
  output logic [CNT_W-1:0] score
);

  logic [LINE_CNT_W-1:0] lock_lines;
  logic [CNT_W:0]        sum_c;

  always_comb sum_c = {1'b0, score} + {1'b0, line_score(lock_lines)};

  // Line count resets at the end of each lock; it stops at 4 since the table tops out there.
  always_ff @(posedge pclk) begin
    if (rst) begin
      score      <= '0;
      lock_lines <= '0;
    end else if (lock_done) begin
      score      <= sum_c[CNT_W] ? '1 : sum_c[CNT_W-1:0];
      lock_lines <= '0;
    end else if (line_inc && (lock_lines != LINE_CNT_W'(4))) begin
      lock_lines <= lock_lines + LINE_CNT_W'(1);
    end
  end

endmodule

// File: rtl/board_ctl.sv
// Playfield occupancy grid: lock write, full-line scan/clear, collision query, draw read.
// Optional score output enabled by defining BOARD_SCORE_EN.
module board_ctl
  import board_pkg::*;
#(
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned RW   = RW_DEF,
  parameter int unsigned CW   = CW_DEF
) (
  input  logic             pclk,
  input  logic             rst,
  board_ctl_if.slave       lk,
  input  logic [RW-1:0]    rd_row,
  input  logic [CW-1:0]    rd_col,
  output logic             rd_cell,
  output logic             busy,
  output logic [CNT_W-1:0] lines_cleared,
  output logic             game_over
`ifdef BOARD_SCORE_EN
  ,
  output logic [CNT_W-1:0] score
`endif
);

  localparam logic [RW-1:0] ROWS_L   = RW'(ROWS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COLS_L   = CW'(COLS);

  state_t          state, state_nx;
  logic [COLS-1:0] grid [ROWS];
  logic [RW-1:0]   scan_row, shift_row, lk_row_q;
  logic [CW-1:0]   lk_col_q;

  logic accept_c, lock_in_range_c, lock_hit_c, scan_full_c;
  logic take_lock_c, set_go_c, line_inc_c;

  assign lk.lock_ready = (state == IDLE) && !game_over;
  assign busy          = (state != IDLE);
  assign accept_c      = lk.lock_valid && lk.lock_ready;
  assign scan_full_c   = (grid[scan_row] == '1);

  // Landing into a filled cell or the top row ends the game.
  always_comb begin
    lock_in_range_c = (lk.lock_row < ROWS_L) && (lk.lock_col < COLS_L);
    lock_hit_c      = 1'b0;
    if (lock_in_range_c)
      lock_hit_c = grid[lk.lock_row][lk.lock_col] || (lk.lock_row == '0);
  end

  // Walls and floor read as solid.
  always_comb begin
    lk.q_occupied = 1'b1;
    if ((lk.q_row < ROWS_L) && (lk.q_col < COLS_L))
      lk.q_occupied = grid[lk.q_row][lk.q_col];
  end

  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    take_lock_c = 1'b0;
    set_go_c    = 1'b0;
    line_inc_c  = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c && lock_in_range_c) begin
          take_lock_c = 1'b1;
          set_go_c    = lock_hit_c;
          state_nx    = WRITE;
        end
      end
      WRITE: state_nx = game_over ? IDLE : SCAN;
      SCAN: begin
        if (scan_full_c)           state_nx = SHIFT;
        else if (scan_row == '0)   state_nx = IDLE;
      end
      SHIFT: begin
        if (shift_row == '0) begin
          line_inc_c = 1'b1;
          state_nx   = SCAN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) grid[r] <= '0;
      scan_row      <= '0;
      shift_row     <= '0;
      lk_row_q      <= '0;
      lk_col_q      <= '0;
      lines_cleared <= '0;
      game_over     <= 1'b0;
      rd_cell       <= 1'b0;
    end else begin
      if (take_lock_c) begin
        lk_row_q <= lk.lock_row;
        lk_col_q <= lk.lock_col;
      end
      if (set_go_c) game_over <= 1'b1;

      case (state)
        WRITE: begin
          grid[lk_row_q][lk_col_q] <= 1'b1;
          scan_row                 <= ROW_LAST;
        end
        SCAN: begin
          if (scan_full_c)          shift_row <= scan_row;
          else if (scan_row != '0)  scan_row  <= scan_row - RW'(1);
        end
        SHIFT: begin
          // Pull each row down from the full line to the top; row 0 refills empty.
          if (shift_row == '0) begin
            grid[0] <= '0;
          end else begin
            grid[shift_row] <= grid[shift_row - RW'(1)];
            shift_row       <= shift_row - RW'(1);
          end
        end
        default: ;
      endcase

      if (line_inc_c) lines_cleared <= lines_cleared + CNT_W'(1);

      if ((rd_row < ROWS_L) && (rd_col < COLS_L)) rd_cell <= grid[rd_row][rd_col];
      else                                        rd_cell <= 1'b0;
    end
  end

`ifdef BOARD_SCORE_EN
  logic lock_done_c;
  assign lock_done_c = (state == SCAN) && !scan_full_c && (scan_row == '0);

  board_score u_score (
    .pclk      (pclk),
    .rst       (rst),
    .line_inc  (line_inc_c),
    .lock_done (lock_done_c),
    .score     (score)
  );
`endif

endmodule

// File: tb/tb_board_ctl.sv
// Directed and randomized checks of board_ctl against a row-list playfield model.
module tb_board_ctl;

  localparam int unsigned ROWS = 20;
  localparam int unsigned COLS = 10;
  localparam int unsigned RW   = 5;
  localparam int unsigned CW   = 4;

  logic          pclk = 1'b0;
  logic          rst;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic          rd_cell, busy, game_over;
  logic [15:0]   lines_cleared;
`ifdef BOARD_SCORE_EN
  logic [15:0]   score;
`endif

  always #5 pclk = ~pclk;

  board_ctl_if bus ();

  board_ctl dut (
    .pclk          (pclk),
    .rst           (rst),
    .lk            (bus),
    .rd_row        (rd_row),
    .rd_col        (rd_col),
    .rd_cell       (rd_cell),
    .busy          (busy),
    .lines_cleared (lines_cleared),
    .game_over     (game_over)
`ifdef BOARD_SCORE_EN
    ,
    .score         (score)
`endif
  );

  // Reference playfield
  bit [COLS-1:0] m_grid [ROWS];
  logic [15:0]   m_lines;
  bit            m_go;
  int            m_score;
  int            score_tbl [5] = '{0, 1, 3, 5, 8};

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) m_grid[r] = '0;
    m_lines = '0;
    m_go    = 1'b0;
    m_score = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.lock_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // kind: 0 dropped, 1 game over, 2 normal; lat = edges after accept until ready again
  task automatic model_lock(input int r, input int c, output int kind, output int lat);
    int n;
    lat = 0;
    if (r >= ROWS || c >= COLS) begin
      kind = 0;
      return;
    end
    if (m_grid[r][c] || r == 0) begin
      m_grid[r][c] = 1'b1;
      m_go = 1'b1;
      kind = 1;
      return;
    end
    m_grid[r][c] = 1'b1;
    kind = 2;
    lat  = 21;
    n    = 0;
    for (int s = ROWS - 1; s >= 0; s--) begin
      while (&m_grid[s]) begin
        for (int k = s; k > 0; k--) m_grid[k] = m_grid[k-1];
        m_grid[0] = '0;
        lat += s + 2;
        n++;
        m_lines++;
      end
    end
    m_score += score_tbl[(n > 4) ? 4 : n];
    if (m_score > 65535) m_score = 65535;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_lines"}, 32'(lines_cleared), 32'(m_lines));
    check({tag, "_go"}, 32'(game_over), 32'(m_go));
`ifdef BOARD_SCORE_EN
    check({tag, "_score"}, 32'(score), 32'(m_score));
`endif
  endtask

  task automatic do_lock(input int r, input int c);
    int kind, lat, n, w;
    bus.lock_valid = 1'b1;
    bus.lock_row   = RW'(r);
    bus.lock_col   = CW'(c);
    w = 0;
    while (!bus.lock_ready && w < 200) begin
      tick();
      w++;
    end
    if (!bus.lock_ready) begin
      check("ready_wait", 32'(bus.lock_ready), 32'd1);
      bus.lock_valid = 1'b0;
      return;
    end
    tick();
    bus.lock_valid = 1'b0;
    model_lock(r, c, kind, lat);
    if (kind == 0) begin
      check("drop_busy", 32'(busy), 32'd0);
      check("drop_ready", 32'(bus.lock_ready), 32'd1);
    end else if (kind == 1) begin
      check("go_ready", 32'(bus.lock_ready), 32'd0);
      tick();
      tick();
      check("go_busy", 32'(busy), 32'd0);
      check("go_ready_hold", 32'(bus.lock_ready), 32'd0);
    end else begin
      n = 0;
      while (!bus.lock_ready && n < 1000) begin
        tick();
        n++;
      end
      check($sformatf("latency(%0d,%0d)", r, c), 32'(n), 32'(lat));
      check("idle_busy", 32'(busy), 32'd0);
    end
    check_status("lock");
  endtask

  task automatic check_grid(input string tag);
    logic [COLS-1:0] v;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        bus.q_row = RW'(r);
        bus.q_col = CW'(c);
        #1;
        v[c] = bus.q_occupied;
      end
      check($sformatf("%s_row%0d", tag, r), 32'(v), 32'(m_grid[r]));
    end
  endtask

  task automatic check_query(input int r, input int c);
    bit exp;
    exp = (r >= ROWS || c >= COLS) ? 1'b1 : m_grid[r][c];
    bus.q_row = RW'(r);
    bus.q_col = CW'(c);
    #1;
    check($sformatf("q(%0d,%0d)", r, c), 32'(bus.q_occupied), 32'(exp));
  endtask

  task automatic check_rd(input int r, input int c);
    bit exp;
    exp = (r >= ROWS || c >= COLS) ? 1'b0 : m_grid[r][c];
    rd_row = RW'(r);
    rd_col = CW'(c);
    tick();
    check($sformatf("rd(%0d,%0d)", r, c), 32'(rd_cell), 32'(exp));
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int p, r, c, k;
    int empties [$];
    vectors = 0;
    miscompares = 0;
    bus.lock_valid = 1'b0;
    bus.lock_row = '0;
    bus.lock_col = '0;
    bus.q_row = '0;
    bus.q_col = '0;
    rd_row = '0;
    rd_col = '0;
    apply_reset();

    // reset state
    check("rst_ready", 32'(bus.lock_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd", 32'(rd_cell), 32'd0);
    check_status("rst");
    check_query(19, 4);

    // single lock, no clear
    do_lock(19, 4);
    check_query(19, 4);
    check_query(19, 5);
    check_rd(19, 4);

    // one line clear with a cell above
    do_lock(18, 4);
    for (int i = 0; i < COLS; i++) if (i != 4) do_lock(19, i);
    check_grid("clr1");

    // two stacked near-full rows cleared by successive locks
    apply_reset();
    for (int i = 0; i < COLS - 1; i++) do_lock(19, i);
    for (int i = 0; i < COLS - 1; i++) do_lock(18, i);
    do_lock(19, 9);
    do_lock(19, 9);
    check_grid("clr2");

    // out-of-range locks are dropped; walls and floor are solid
    do_lock(20, 0);
    do_lock(3, 10);
    check_query(20, 0);
    check_query(3, 10);
    check_query(31, 15);
    check_rd(20, 0);
    check_grid("oor");

    // lock onto a filled cell ends the game; further locks are not taken
    do_lock(5, 3);
    do_lock(5, 3);
    bus.lock_valid = 1'b1;
    bus.lock_row = RW'(7);
    bus.lock_col = CW'(7);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("go_blocked_ready", 32'(bus.lock_ready), 32'd0);
    end
    bus.lock_valid = 1'b0;
    check_status("go_hold");
    check_grid("go1");

    // lock into top row ends the game but is still written
    apply_reset();
    do_lock(0, 0);
    check_grid("go_top");

    // reset in the middle of a line shift
    apply_reset();
    do_lock(10, 2);
    for (int i = 0; i < COLS - 1; i++) do_lock(19, i);
    bus.lock_valid = 1'b1;
    bus.lock_row = RW'(19);
    bus.lock_col = CW'(9);
    tick();
    bus.lock_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("midshift_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("midshift_rst_busy", 32'(busy), 32'd0);
    check("midshift_rst_ready", 32'(bus.lock_ready), 32'd1);
    check_status("midshift");
    check_grid("midshift");

    // randomized play
    apply_reset();
    for (int it = 0; it < 120; it++) begin
      if (m_go) apply_reset();
      p = $urandom_range(0, 39);
      if (p == 0) begin
        r = $urandom_range(ROWS, 31);
        c = $urandom_range(0, 15);
      end else if (p == 1) begin
        r = $urandom_range(0, ROWS - 1);
        c = $urandom_range(0, COLS - 1);
      end else begin
        r = $urandom_range(15, ROWS - 1);
        empties.delete();
        for (int i = 0; i < COLS; i++) if (!m_grid[r][i]) empties.push_back(i);
        k = $urandom_range(0, empties.size() - 1);
        c = empties[k];
      end
      do_lock(r, c);
      check_grid("rand");
      check_rd($urandom_range(0, 21), $urandom_range(0, 11));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
